// File: rtl/alu_result_display.sv
// Shows the core's 32-bit ALU result as 8 hex digits on a multiplexed, active-low 7-segment display.
// Latency: outputs are registered one cycle after the scan index; a new value appears at the next frame boundary.
// Backpressure: none; value_i is sampled every cycle unless hold_i freezes the shadow copy.
module alu_result_display #(
    parameter int WIDTH       = 32,
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value_i,
    input  logic             hold_i,
    output logic [6:0]       seg_o,
    output logic [7:0]       an_o,
    output logic             dp_o
);

    localparam int             CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] disp;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic             wrap;
    logic             frame_end;

    logic [3:0]       cur_nib;
    logic [7:0]       upper_nz;
    logic             blank_cur;
    logic [6:0]       seg_nxt;
    logic [7:0]       an_nxt;
    logic             dp_nxt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign wrap      = (cnt == CNT_MAX);
    assign frame_end = wrap && (idx == 3'd7);

    // hold_i only gates the shadow; disp is always reloaded at frame end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (!hold_i) begin
            shadow <= value_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            idx  <= 3'd0;
            disp <= '0;
        end else begin
            if (wrap) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (frame_end) begin
                disp <= shadow;
            end
        end
    end

    // upper_nz[k]: any of nibbles k..7 nonzero
    for (genvar k = 0; k < 8; k++) begin : g_nz
        assign upper_nz[k] = |disp[WIDTH-1:4*k];
    end

    assign cur_nib   = disp[{idx, 2'b00} +: 4];
    assign blank_cur = BLANK_LZ && (idx != 3'd0) && !upper_nz[idx];

    always_comb begin
        seg_nxt = hex_to_seg(cur_nib);
        an_nxt  = ~(8'b1 << idx);
        dp_nxt  = 1'b1;
        if (blank_cur) begin
            seg_nxt = 7'h7F;
        end
        if ((idx == 3'd0) && hold_i) begin
            dp_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_o <= 7'h7F;
            an_o  <= 8'hFF;
            dp_o  <= 1'b1;
        end else begin
            seg_o <= seg_nxt;
            an_o  <= an_nxt;
            dp_o  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with REFRESH_DIV=4; two instances cover BLANK_LZ=1 and BLANK_LZ=0.
// Frame timing: after reset release, edge n (n>=1) shows digit (n-1)/4 mod 8; disp reloads on every 32nd edge.
module tb_alu_result_display;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [31:0] value_i = 32'h0;
    logic        hold_i  = 1'b0;

    logic [6:0] seg_b, seg_n;
    logic [7:0] an_b, an_n;
    logic       dp_b, dp_n;

    int n_checks = 0;
    int n_pass   = 0;
    int ec       = 0;

    typedef struct packed {
        logic [31:0]      value;
        logic [7:0][6:0]  seg_b;
        logic [7:0][6:0]  seg_n;
    } vec_t;

    vec_t vecs [5];

    alu_result_display #(.WIDTH(32), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_b (
        .clk(clk), .rst(rst), .value_i(value_i), .hold_i(hold_i),
        .seg_o(seg_b), .an_o(an_b), .dp_o(dp_b)
    );

    alu_result_display #(.WIDTH(32), .REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_n (
        .clk(clk), .rst(rst), .value_i(value_i), .hold_i(hold_i),
        .seg_o(seg_n), .an_o(an_n), .dp_o(dp_n)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        ec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ec);
    endtask

    task automatic check_digit(input int d, input logic [6:0] eb, input logic [6:0] en, input int tail);
        logic [7:0] exp_an;
        logic       exp_dp;
        step();
        exp_an = ~(8'b1 << d);
        exp_dp = !((d == 0) && hold_i);
        chk($sformatf("an_blz d%0d", d), {24'h0, an_b}, {24'h0, exp_an});
        chk($sformatf("an_all d%0d", d), {24'h0, an_n}, {24'h0, exp_an});
        chk($sformatf("seg_blz d%0d", d), {25'h0, seg_b}, {25'h0, eb});
        chk($sformatf("seg_all d%0d", d), {25'h0, seg_n}, {25'h0, en});
        chk($sformatf("dp_blz d%0d", d), {31'h0, dp_b}, {31'h0, exp_dp});
        chk($sformatf("dp_all d%0d", d), {31'h0, dp_n}, {31'h0, exp_dp});
        repeat (tail) step();
    endtask

    task automatic check_frame(input logic [7:0][6:0] eb, input logic [7:0][6:0] en);
        for (int d = 0; d < 8; d++) check_digit(d, eb[d], en[d], 3);
    endtask

    task automatic skip_frame();
        repeat (32) step();
    endtask

    function automatic logic [7:0][6:0] rep(input logic [6:0] s);
        logic [7:0][6:0] r;
        for (int i = 0; i < 8; i++) r[i] = s;
        return r;
    endfunction

    function automatic logic [7:0][6:0] first_then(input logic [6:0] d0, input logic [6:0] rest);
        logic [7:0][6:0] r;
        r    = rep(rest);
        r[0] = d0;
        return r;
    endfunction

    initial begin
        // seg lists are digit7 .. digit0
        vecs[0].value = 32'h89ABCDEF;
        vecs[0].seg_b = {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        vecs[0].seg_n = {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        vecs[1].value = 32'h00000A01;
        vecs[1].seg_b = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h79};
        vecs[1].seg_n = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40, 7'h79};
        vecs[2].value = 32'h00000000;
        vecs[2].seg_b = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        vecs[2].seg_n = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        vecs[3].value = 32'h01234567;
        vecs[3].seg_b = {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
        vecs[3].seg_n = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
        vecs[4].value = 32'h00F00000;
        vecs[4].seg_b = {7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        vecs[4].seg_n = {7'h40, 7'h40, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst an_blz", {24'h0, an_b}, 32'hFF);
        chk("rst an_all", {24'h0, an_n}, 32'hFF);
        chk("rst seg_blz", {25'h0, seg_b}, 32'h7F);
        chk("rst seg_all", {25'h0, seg_n}, 32'h7F);
        chk("rst dp_blz", {31'h0, dp_b}, 32'h1);
        chk("rst dp_all", {31'h0, dp_n}, 32'h1);
        rst = 1'b0;
        ec  = 0;

        // Frame 0 shows the reset disp (0)
        check_frame(vecs[2].seg_b, vecs[2].seg_n);

        // Table: load, let one frame pass, check the following frame
        for (int i = 0; i < 5; i++) begin
            value_i = vecs[i].value;
            skip_frame();
            check_frame(vecs[i].seg_b, vecs[i].seg_n);
        end

        // Tear-free update at idx=3
        value_i = 32'h11111111;
        skip_frame();
        check_frame(rep(7'h79), rep(7'h79));
        for (int d = 0; d < 8; d++) begin
            if (d == 3) value_i = 32'h22222222;
            check_digit(d, 7'h79, 7'h79, 3);
        end
        check_frame(rep(7'h24), rep(7'h24));

        // Hold freezes shadow; dp marks idx 0 while held
        value_i = 32'h00000005;
        skip_frame();
        check_frame(first_then(7'h12, 7'h7F), first_then(7'h12, 7'h40));
        hold_i  = 1'b1;
        value_i = 32'h00000007;
        check_frame(first_then(7'h12, 7'h7F), first_then(7'h12, 7'h40));
        check_frame(first_then(7'h12, 7'h7F), first_then(7'h12, 7'h40));
        hold_i = 1'b0;
        check_frame(first_then(7'h12, 7'h7F), first_then(7'h12, 7'h40));
        check_frame(first_then(7'h78, 7'h7F), first_then(7'h78, 7'h40));

        // hold_i rising on the frame-boundary edge: disp still takes the pre-edge shadow
        value_i = 32'h00000001;
        skip_frame();
        for (int d = 0; d < 7; d++) begin
            if (d == 4) value_i = 32'h00000003;
            check_digit(d, (d == 0) ? 7'h79 : 7'h7F, (d == 0) ? 7'h79 : 7'h40, 3);
        end
        check_digit(7, 7'h7F, 7'h40, 2);
        hold_i  = 1'b1;
        value_i = 32'h00000004;
        step();
        check_frame(first_then(7'h30, 7'h7F), first_then(7'h30, 7'h40));
        hold_i = 1'b0;
        check_frame(first_then(7'h30, 7'h7F), first_then(7'h30, 7'h40));
        check_frame(first_then(7'h19, 7'h7F), first_then(7'h19, 7'h40));

        // Asynchronous reset mid-digit, then scan restarts at idx 0 / counter 0
        value_i = 32'h89ABCDEF;
        skip_frame();
        repeat (10) step();
        rst = 1'b1;
        #1;
        chk("midrst an_blz", {24'h0, an_b}, 32'hFF);
        chk("midrst an_all", {24'h0, an_n}, 32'hFF);
        chk("midrst seg_blz", {25'h0, seg_b}, 32'h7F);
        chk("midrst seg_all", {25'h0, seg_n}, 32'h7F);
        chk("midrst dp_blz", {31'h0, dp_b}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ec  = 0;
        check_digit(0, 7'h40, 7'h40, 3);
        check_digit(1, 7'h7F, 7'h40, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
- Output peripheral directly downstream of the MIPS core.
- Consumes the core's 32-bit ALU result and shows it as 8 hex digits on a time-multiplexed 7-segment display.
- Input is double-registered (live shadow, frame-synchronous display copy) to prevent tearing mid-scan.
- Optional freeze and leading-zero blanking.

Parameters:
- WIDTH, 32, width of value_i; fixed at 8 nibbles (values other than 32 not supported).
- REFRESH_DIV, 50000, clk cycles each digit is driven (>=2).
- BLANK_LZ, 1, 1 = blank leading zero digits; 0 = show all 8 digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- value_i  input  32  ALU result from the core (ALUOutput).
- hold_i  input  1  1 = freeze displayed value.
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an_o  output  8  digit enables, active-low; an_o[k] selects nibble k (k=0 is the LS nibble).
- dp_o  output  1  decimal point, active-low.

Behaviour:
- One clock domain. Reset is asynchronous and active-high: clk and rst, rst asynchronous active-high.
- Reset values (all registers):
  - shadow, disp, refresh counter, digit index: 0.
  - an_o = 8'hFF, seg_o = 7'h7F, dp_o = 1 (everything dark).
- Shadow register:
  - Loads value_i every clk while hold_i=0.
  - Keeps its value while hold_i=1.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit index increments mod 8 (7 -> 0).
- Frame boundary: the cycle in which the counter wraps AND digit index = 7.
  - disp <= shadow on that edge only.
  - A value change mid-frame never appears until the next frame.
- Outputs are registered; they reflect the current digit index with 1 cycle latency.
  - an_o = ~(8'b1 << idx).
  - seg_o = decode(disp[4*idx+3 : 4*idx]).
- Decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k>0 is blanked (seg_o=7F) when nibbles k..7 of disp are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - The anode still cycles normally.
- dp_o = 0 only when idx=0 and hold_i=1 (freeze indicator); otherwise 1.
- Simultaneous events:
  - hold_i rising on a frame boundary: disp still takes shadow as it stood before that edge.
  - hold_i only gates the shadow register, never disp directly.
- Reset mid-scan: all state returns to reset values immediately (asynchronous).
  - Scanning restarts at idx 0 with counter 0 after rst deasserts.
- No combinational path from value_i to any output.

Test Plan:
(all scenarios use REFRESH_DIV=4)
- Reset: assert rst mid-run -> an_o=FF, seg_o=7F, dp_o=1 at once. After release, the first registered edge gives an_o=FE, seg_o=40 (disp=0).
- Full scan: value_i=32'h89ABCDEF held two frames -> second frame digits 0..7 show seg 0E,06,21,46,03,08,10,00. an_o steps FE,FD,...,7F every 4 cycles, then wraps to FE.
- Blanking: value_i=32'h0000_0A01, BLANK_LZ=1 -> digits 0,1,2 show 79,40,08; digits 3..7 show 7F. Same with BLANK_LZ=0 -> digits 3..7 show 40.
- Tear-free update: change value_i from 32'h11111111 to 32'h22222222 while idx=3 -> remaining digits of that frame still show 79. Next frame shows 24 on all digits.
- Hold: set hold_i=1 with shadow=32'h00000005, then drive value_i=32'h7 -> display keeps 12 on digit 0 with dp_o=0 while idx=0. Release hold -> 78 appears from the next frame.
- Zero: value_i=0, BLANK_LZ=1 -> digit 0 shows 40; all other digits show 7F.
